// File: rtl/ex_wb_stage.sv
// Execute/write-back stage: ALU, branch/jump resolution, data-memory access and write-back register.
// Optional define EX_MISALIGN_TRAP_EN enables the sticky misaligned-access trap.
module ex_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic        id_imm_sel,
    input  logic        id_alu,
    input  logic        id_lui,
    input  logic        id_jal,
    input  logic        id_jalr,
    input  logic        id_branch,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        id_arith_sub,
    input  logic [2:0]  id_funct3,
    input  logic [4:0]  id_rd,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        exception
);

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t      state, state_next;
    logic        kill, effective, is_mem, misaligned, taken;
    logic        req_int, redirect_int, retire, writes_reg;
    logic [31:0] op2, alu_result, sra_result, eff_addr, acc_addr, result;
    logic [31:0] load_data, rdata_shifted, st_wdata, target;
    logic [3:0]  st_be;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_be;
    logic        hold_we;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign effective  = id_valid && !kill;
    assign is_mem     = id_mem_to_reg || id_mem_write;
    assign eff_addr   = rs1_data + id_imm;
    assign op2        = id_imm_sel ? id_imm : rs2_data;
    assign sra_result = $signed(rs1_data) >>> op2[4:0];
    assign writes_reg = (id_alu || id_lui || id_jal || id_jalr || id_mem_to_reg) && (id_rd != 5'd0);

`ifdef EX_MISALIGN_TRAP_EN
    assign misaligned = is_mem && (((id_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                                   ((id_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            exception <= 1'b0;
        else if (state == IDLE && effective && misaligned)
            exception <= 1'b1;
    end
`else
    assign misaligned = 1'b0;
    assign exception  = 1'b0;
`endif

    always_comb begin
        alu_result = '0;
        case (id_funct3)
            3'd0: alu_result = id_arith_sub ? rs1_data - op2 : rs1_data + op2;
            3'd1: alu_result = rs1_data << op2[4:0];
            3'd2: alu_result = {31'b0, $signed(rs1_data) < $signed(op2)};
            3'd3: alu_result = {31'b0, rs1_data < op2};
            3'd4: alu_result = rs1_data ^ op2;
            3'd5: alu_result = id_arith_sub ? sra_result : rs1_data >> op2[4:0];
            3'd6: alu_result = rs1_data | op2;
            3'd7: alu_result = rs1_data & op2;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (id_funct3)
            3'd0: taken = rs1_data == rs2_data;
            3'd1: taken = rs1_data != rs2_data;
            3'd4: taken = $signed(rs1_data) < $signed(rs2_data);
            3'd5: taken = $signed(rs1_data) >= $signed(rs2_data);
            3'd6: taken = rs1_data < rs2_data;
            3'd7: taken = rs1_data >= rs2_data;
            default: taken = 1'b0;
        endcase
    end

    // Store data is replicated across lanes; byte enables pick the addressed lane.
    always_comb begin
        st_wdata = rs2_data;
        st_be    = 4'b1111;
        case (id_funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_be    = 4'b0001 << eff_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_be    = 4'b0011 << {eff_addr[1], 1'b0};
            end
            default: begin
                st_wdata = rs2_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    assign acc_addr      = (state == MEM_WAIT) ? hold_addr : eff_addr;
    assign rdata_shifted = dmem_rdata >> {acc_addr[1:0], 3'b000};
    assign ld_byte       = rdata_shifted[7:0];
    assign ld_half       = acc_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        case (id_funct3)
            3'd0: load_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1: load_data = {{16{ld_half[15]}}, ld_half};
            3'd4: load_data = {24'b0, ld_byte};
            3'd5: load_data = {16'b0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        result = alu_result;
        if (id_lui)
            result = id_imm;
        else if (id_jal || id_jalr)
            result = id_pc + 32'd4;
        else if (id_mem_to_reg)
            result = load_data;
    end

    assign target = id_jalr ? ((rs1_data + id_imm) & ~32'd1) : (id_pc + id_imm);

    always_comb begin
        state_next   = state;
        req_int      = 1'b0;
        retire       = 1'b0;
        redirect_int = 1'b0;
        case (state)
            IDLE: begin
                if (effective) begin
                    if (is_mem && !misaligned) begin
                        req_int = 1'b1;
                        if (dmem_ack)
                            retire = 1'b1;
                        else
                            state_next = MEM_WAIT;
                    end else begin
                        retire       = 1'b1;
                        redirect_int = !is_mem && (id_jal || id_jalr || (id_branch && taken));
                    end
                end
            end
            MEM_WAIT: begin
                req_int = 1'b1;
                if (dmem_ack) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gating with reset makes the request drop the instant reset asserts, even mid-access.
    assign dmem_req    = reset && req_int;
    assign dmem_we     = dmem_req && ((state == MEM_WAIT) ? hold_we : id_mem_write);
    assign dmem_addr   = dmem_req ? {acc_addr[31:2], 2'b00} : 32'h0;
    assign dmem_wdata  = dmem_req ? ((state == MEM_WAIT) ? hold_wdata : st_wdata) : 32'h0;
    assign dmem_be     = dmem_req ? ((state == MEM_WAIT) ? hold_be : st_be) : 4'b0000;
    assign stall       = dmem_req && !dmem_ack;
    assign redirect    = reset && redirect_int;
    assign redirect_pc = redirect ? target : RESET_PC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            kill       <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'h0;
            wb_pc      <= RESET_PC;
            hold_addr  <= 32'h0;
            hold_wdata <= 32'h0;
            hold_be    <= 4'b0000;
            hold_we    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE)
                kill <= redirect_int;
            wb_we <= retire && writes_reg && !misaligned;
            if (retire) begin
                wb_rd   <= id_rd;
                wb_data <= result;
                wb_pc   <= id_pc;
            end
            if (state == IDLE && state_next == MEM_WAIT) begin
                hold_addr  <= eff_addr;
                hold_wdata <= st_wdata;
                hold_be    <= st_be;
                hold_we    <= id_mem_write;
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: write-back results go through a scoreboard queue,
// memory/redirect/stall outputs are checked in the cycle they are produced.
module tb_ex_wb_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        imm_sel, alu, lui, jal, jalr, branch, mem_write, mem_to_reg, arith_sub;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] rs1, rs2;
    } instr_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_imm_sel, id_alu, id_lui, id_jal, id_jalr, id_branch;
    logic        id_mem_write, id_mem_to_reg, id_arith_sub;
    logic [31:0] id_pc, id_imm, rs1_data, rs2_data, dmem_rdata;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rd;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, redirect, wb_we, exception;
    logic [31:0] dmem_addr, dmem_wdata, redirect_pc, wb_data, wb_pc;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int total = 0;
    int bad = 0;
    wb_exp_t sb[$];
    instr_t  ins;

    ex_wb_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_imm_sel(id_imm_sel), .id_alu(id_alu), .id_lui(id_lui), .id_jal(id_jal),
        .id_jalr(id_jalr), .id_branch(id_branch), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_arith_sub(id_arith_sub), .id_funct3(id_funct3),
        .id_rd(id_rd), .rs1_data(rs1_data), .rs2_data(rs2_data), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .exception(exception)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input instr_t i);
        id_valid      = i.valid;
        id_pc         = i.pc;
        id_imm        = i.imm;
        id_imm_sel    = i.imm_sel;
        id_alu        = i.alu;
        id_lui        = i.lui;
        id_jal        = i.jal;
        id_jalr       = i.jalr;
        id_branch     = i.branch;
        id_mem_write  = i.mem_write;
        id_mem_to_reg = i.mem_to_reg;
        id_arith_sub  = i.arith_sub;
        id_funct3     = i.funct3;
        id_rd         = i.rd;
        rs1_data      = i.rs1;
        rs2_data      = i.rs2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        wb_exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic checkWbPop(input string tag);
        wb_exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_we"}, {31'b0, wb_we}, {31'b0, e.we});
            if (e.we) begin
                checkOutput({tag, "_rd"}, {27'b0, wb_rd}, {27'b0, e.rd});
                checkOutput({tag, "_data"}, wb_data, e.data);
                checkOutput({tag, "_pc"}, wb_pc, e.pc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        ins = '0;
        applyStimulus(ins);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        reset = 1'b0;
        #3;
        checkOutput("rst_wb_pc", wb_pc, 32'h0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
        checkOutput("rst_wb_we", {31'b0, wb_we}, 32'h0);
        checkOutput("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("rst_exception", {31'b0, exception}, 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // SUB 10-3 -> x5
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h10; ins.alu = 1; ins.arith_sub = 1;
        ins.rs1 = 32'd10; ins.rs2 = 32'd3; ins.rd = 5'd5;
        applyStimulus(ins); pushExp(1, 5, 32'd7, 32'h10);
        #1 checkOutput("sub_redirect", {31'b0, redirect}, 32'h0);

        // ADDI 0x100 + (-16) -> x6
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h14; ins.alu = 1; ins.imm_sel = 1;
        ins.rs1 = 32'h100; ins.imm = 32'hFFFF_FFF0; ins.rs2 = 32'h5555; ins.rd = 5'd6;
        applyStimulus(ins); pushExp(1, 6, 32'hF0, 32'h14);
        #1 checkWbPop("sub");

        // SRAI 0x80000000 >>> 4 -> x7
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h18; ins.alu = 1; ins.imm_sel = 1; ins.arith_sub = 1;
        ins.funct3 = 3'd5; ins.rs1 = 32'h8000_0000; ins.imm = 32'd4; ins.rd = 5'd7;
        applyStimulus(ins); pushExp(1, 7, 32'hF800_0000, 32'h18);
        #1 checkWbPop("addi");

        // SLTU 1 < 0xFFFFFFFF -> x8
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h1C; ins.alu = 1; ins.funct3 = 3'd3;
        ins.rs1 = 32'd1; ins.rs2 = 32'hFFFF_FFFF; ins.rd = 5'd8;
        applyStimulus(ins); pushExp(1, 8, 32'd1, 32'h1C);
        #1 checkWbPop("srai");

        // LUI -> x9
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h20; ins.lui = 1; ins.imm = 32'h1234_5000; ins.rd = 5'd9;
        applyStimulus(ins); pushExp(1, 9, 32'h1234_5000, 32'h20);
        #1 checkWbPop("sltu");

        // JAL from 0x200, +0x40 -> x1 = 0x204
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h200; ins.jal = 1; ins.imm = 32'h40; ins.rd = 5'd1;
        applyStimulus(ins); pushExp(1, 1, 32'h204, 32'h200);
        #1 checkWbPop("lui");
        checkOutput("jal_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("jal_target", redirect_pc, 32'h240);

        // wrong-path ADD after JAL is killed
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h204; ins.alu = 1; ins.rs1 = 32'd1; ins.rs2 = 32'd2; ins.rd = 5'd10;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("jal");
        checkOutput("killed_redirect", {31'b0, redirect}, 32'h0);

        // BEQ 4==4 from 0x100, +0x20
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h100; ins.branch = 1; ins.imm = 32'h20;
        ins.rs1 = 32'd4; ins.rs2 = 32'd4;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("killed_add");
        checkOutput("beq_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("beq_target", redirect_pc, 32'h120);

        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h104; ins.alu = 1; ins.rs1 = 32'd1; ins.rs2 = 32'd2; ins.rd = 5'd11;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("beq");

        // BNE 5!=5 is not taken
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h120; ins.branch = 1; ins.funct3 = 3'd1; ins.imm = 32'h80;
        ins.rs1 = 32'd5; ins.rs2 = 32'd5;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("killed_after_beq");
        checkOutput("bne_redirect", {31'b0, redirect}, 32'h0);

        // JALR target clears bit 0
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h300; ins.jalr = 1; ins.rs1 = 32'h1001; ins.imm = 32'h10; ins.rd = 5'd2;
        applyStimulus(ins); pushExp(1, 2, 32'h304, 32'h300);
        #1 checkWbPop("bne");
        checkOutput("jalr_target", redirect_pc, 32'h1010);

        tick();
        ins = '0;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("jalr");

        // LW 0x40 with two wait cycles
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h400; ins.mem_to_reg = 1; ins.imm_sel = 1; ins.funct3 = 3'd2;
        ins.rs1 = 32'h3C; ins.imm = 32'h4; ins.rd = 5'd12;
        applyStimulus(ins); pushExp(1, 12, 32'hDEAD_BEEF, 32'h400);
        #1 checkWbPop("bubble");
        checkOutput("lw_req", {31'b0, dmem_req}, 32'h1);
        checkOutput("lw_addr", dmem_addr, 32'h40);
        checkOutput("lw_stall0", {31'b0, stall}, 32'h1);
        tick();
        #1 checkOutput("lw_stall1", {31'b0, stall}, 32'h1);
        checkOutput("lw_wait_wb_we", {31'b0, wb_we}, 32'h0);
        checkOutput("lw_wait_addr", dmem_addr, 32'h40);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1 checkOutput("lw_ack_stall", {31'b0, stall}, 32'h0);

        // LB 0x41, immediate ack
        tick();
        ins.pc = 32'h404; ins.funct3 = 3'd0; ins.rs1 = 32'h40; ins.imm = 32'h1; ins.rd = 5'd13;
        applyStimulus(ins); pushExp(1, 13, 32'hFFFF_FFBE, 32'h404);
        #1 checkWbPop("lw");
        checkOutput("lb_stall", {31'b0, stall}, 32'h0);

        // LHU 0x42
        tick();
        ins.pc = 32'h408; ins.funct3 = 3'd5; ins.imm = 32'h2; ins.rd = 5'd14;
        applyStimulus(ins); pushExp(1, 14, 32'h0000_DEAD, 32'h408);
        #1 checkWbPop("lb");

        // SB 0x43
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h40C; ins.mem_write = 1; ins.funct3 = 3'd0;
        ins.rs1 = 32'h40; ins.imm = 32'h3; ins.rs2 = 32'h0000_00AB;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("lhu");
        checkOutput("sb_be", {28'b0, dmem_be}, 32'h8);
        checkOutput("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_we", {31'b0, dmem_we}, 32'h1);
        checkOutput("sb_addr", dmem_addr, 32'h40);

        // SH 0x42
        tick();
        ins.pc = 32'h410; ins.funct3 = 3'd1; ins.imm = 32'h2; ins.rs2 = 32'h0000_1234;
        applyStimulus(ins); pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("sb");
        checkOutput("sh_be", {28'b0, dmem_be}, 32'hC);
        checkOutput("sh_wdata", dmem_wdata, 32'h1234_1234);

        // LW at misaligned 0x42
        tick();
        dmem_rdata = 32'h1122_3344;
        ins = '0; ins.valid = 1; ins.pc = 32'h414; ins.mem_to_reg = 1; ins.funct3 = 3'd2;
        ins.rs1 = 32'h40; ins.imm = 32'h2; ins.rd = 5'd15;
        applyStimulus(ins);
`ifdef EX_MISALIGN_TRAP_EN
        pushExp(0, 0, 32'h0, 32'h0);
        #1 checkWbPop("sh");
        checkOutput("mis_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("mis_stall", {31'b0, stall}, 32'h0);
`else
        pushExp(1, 15, 32'h1122_3344, 32'h414);
        #1 checkWbPop("sh");
        checkOutput("mis_req", {31'b0, dmem_req}, 32'h1);
        checkOutput("mis_addr", dmem_addr, 32'h40);
`endif
        tick();
        ins = '0; applyStimulus(ins); dmem_ack = 1'b0;
        #1 checkWbPop("misaligned_lw");
`ifdef EX_MISALIGN_TRAP_EN
        checkOutput("mis_exception", {31'b0, exception}, 32'h1);
`else
        checkOutput("mis_exception", {31'b0, exception}, 32'h0);
`endif

        // reset asserted while in MEM_WAIT
        tick();
        ins = '0; ins.valid = 1; ins.pc = 32'h500; ins.mem_to_reg = 1; ins.funct3 = 3'd2;
        ins.rs1 = 32'h80; ins.rd = 5'd3;
        applyStimulus(ins);
        tick();
        #1 checkOutput("pre_rst_stall", {31'b0, stall}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("mid_rst_stall", {31'b0, stall}, 32'h0);
        checkOutput("mid_rst_wb_we", {31'b0, wb_we}, 32'h0);
        checkOutput("mid_rst_wb_rd", {27'b0, wb_rd}, 32'h0);
        checkOutput("mid_rst_wb_data", wb_data, 32'h0);
        checkOutput("mid_rst_wb_pc", wb_pc, 32'h0);
        checkOutput("mid_rst_exception", {31'b0, exception}, 32'h0);
        tick();
        ins = '0; applyStimulus(ins);
        reset = 1'b1;
        tick();

        checkOutput("sb_leftover", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
